// File: rtl/uart_msg_rx_pkg.sv
// Shared definitions for the UART message receiver: frame constants, state
// encodings and the message address map used by the synth and DAC decoders.
package uart_msg_rx_pkg;

  localparam logic [7:0]  SYNC_BYTE           = 8'hA5;
  localparam int          FRAME_PAYLOAD_BYTES = 8;

  // Address map shared with the ks_guitar and dac decoders
  localparam logic [31:0] MSG_ADDR_SYNTH_BASE = 32'h0000_0000;
  localparam logic [31:0] MSG_ADDR_DAC_BASE   = 32'h0000_1000;

  typedef enum logic [1:0] {
    P_HUNT,
    P_ADDR,
    P_DATA,
    P_CSUM
  } parser_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  function automatic logic [7:0] csum_fold(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// UART byte receiver: 2-FF synchronizer, arming after line-high, and a
// start/data/stop sampler that flags good bytes or framing errors.
module uart_rx_byte
  import uart_msg_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       framing_err,
  output logic       rx_idle
);

  localparam logic [15:0] HALF_BIT = 16'(CLKS_PER_BIT / 2);
  localparam logic [15:0] FULL_M1  = 16'(CLKS_PER_BIT - 1);

  rx_state_e   state_reg, state_next;
  logic        rx_meta_reg, rxs_reg;
  logic        armed_reg, armed_next;
  logic [15:0] cnt_reg, cnt_next;
  logic [2:0]  bit_reg, bit_next;
  logic [7:0]  shift_reg, shift_next;
  logic        valid_reg, valid_next;
  logic        ferr_reg, ferr_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_reg <= 1'b0;
      rxs_reg     <= 1'b0;
      state_reg   <= RX_IDLE;
      armed_reg   <= 1'b0;
      cnt_reg     <= '0;
      bit_reg     <= '0;
      shift_reg   <= '0;
      valid_reg   <= 1'b0;
      ferr_reg    <= 1'b0;
    end else begin
      rx_meta_reg <= rx;
      rxs_reg     <= rx_meta_reg;
      state_reg   <= state_next;
      armed_reg   <= armed_next;
      cnt_reg     <= cnt_next;
      bit_reg     <= bit_next;
      shift_reg   <= shift_next;
      valid_reg   <= valid_next;
      ferr_reg    <= ferr_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    armed_next = armed_reg | rxs_reg;
    cnt_next   = cnt_reg;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    valid_next = 1'b0;
    ferr_next  = 1'b0;
    case (state_reg)
      RX_IDLE: begin
        // Armed implies the line was high before, so low here is a falling edge
        if (armed_reg && !rxs_reg) begin
          state_next = RX_START;
          cnt_next   = HALF_BIT;
        end
      end
      RX_START: begin
        if (cnt_reg == '0) begin
          if (!rxs_reg) begin
            state_next = RX_DATA;
            cnt_next   = FULL_M1;
            bit_next   = '0;
          end else begin
            state_next = RX_IDLE;
          end
        end else begin
          cnt_next = cnt_reg - 16'd1;
        end
      end
      RX_DATA: begin
        if (cnt_reg == '0) begin
          shift_next = {rxs_reg, shift_reg[7:1]};
          bit_next   = bit_reg + 3'd1;
          cnt_next   = FULL_M1;
          if (bit_reg == 3'd7) state_next = RX_STOP;
        end else begin
          cnt_next = cnt_reg - 16'd1;
        end
      end
      RX_STOP: begin
        if (cnt_reg == '0) begin
          state_next = RX_IDLE;
          if (rxs_reg) begin
            valid_next = 1'b1;
          end else begin
            ferr_next  = 1'b1;
            armed_next = 1'b0;
          end
        end else begin
          cnt_next = cnt_reg - 16'd1;
        end
      end
      default: state_next = RX_IDLE;
    endcase
  end

  assign byte_valid  = valid_reg;
  assign byte_data   = shift_reg;
  assign framing_err = ferr_reg;
  assign rx_idle     = (state_reg == RX_IDLE);

endmodule

// File: rtl/uart_msg_rx.sv
// Frame parser on top of the UART byte receiver: sync hunt, addr/data capture,
// XOR checksum, inter-byte timeout and the single-cycle msg write strobe.
module uart_msg_rx
  import uart_msg_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int TIMEOUT_BITS = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx,
  output logic        msg_en,
  output logic [31:0] msg_addr,
  output logic [31:0] msg,
  output logic        frame_err,
  output logic        busy
);

  localparam logic [31:0] TIMEOUT_LIMIT_M1 = 32'(TIMEOUT_BITS * CLKS_PER_BIT - 1);

  logic       byte_valid, framing_err, rx_idle;
  logic [7:0] byte_data;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx_byte (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .framing_err(framing_err),
    .rx_idle    (rx_idle)
  );

  parser_state_e pstate_reg, pstate_next;
  logic [2:0]    idx_reg, idx_next;
  logic [31:0]   addr_sr_reg, addr_sr_next;
  logic [31:0]   data_sr_reg, data_sr_next;
  logic [7:0]    csum_reg, csum_next;
  logic [31:0]   idle_cnt_reg, idle_cnt_next;
  logic          msg_en_reg, msg_en_next;
  logic          frame_err_reg, frame_err_next;
  logic [31:0]   msg_addr_reg, msg_addr_next;
  logic [31:0]   msg_reg, msg_next;
  logic          timeout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pstate_reg    <= P_HUNT;
      idx_reg       <= '0;
      addr_sr_reg   <= '0;
      data_sr_reg   <= '0;
      csum_reg      <= '0;
      idle_cnt_reg  <= '0;
      msg_en_reg    <= 1'b0;
      frame_err_reg <= 1'b0;
      msg_addr_reg  <= '0;
      msg_reg       <= '0;
    end else begin
      pstate_reg    <= pstate_next;
      idx_reg       <= idx_next;
      addr_sr_reg   <= addr_sr_next;
      data_sr_reg   <= data_sr_next;
      csum_reg      <= csum_next;
      idle_cnt_reg  <= idle_cnt_next;
      msg_en_reg    <= msg_en_next;
      frame_err_reg <= frame_err_next;
      msg_addr_reg  <= msg_addr_next;
      msg_reg       <= msg_next;
    end
  end

  // Any receiver activity (including a START entry) restarts the idle window
  assign timeout = (pstate_reg != P_HUNT) && rx_idle && (idle_cnt_reg == TIMEOUT_LIMIT_M1);

  always_comb begin
    pstate_next    = pstate_reg;
    idx_next       = idx_reg;
    addr_sr_next   = addr_sr_reg;
    data_sr_next   = data_sr_reg;
    csum_next      = csum_reg;
    msg_en_next    = 1'b0;
    frame_err_next = 1'b0;
    msg_addr_next  = msg_addr_reg;
    msg_next       = msg_reg;
    if (pstate_reg == P_HUNT || !rx_idle) idle_cnt_next = '0;
    else                                  idle_cnt_next = idle_cnt_reg + 32'd1;

    if (framing_err) begin
      if (pstate_reg != P_HUNT) frame_err_next = 1'b1;
      pstate_next = P_HUNT;
    end else if (timeout) begin
      frame_err_next = 1'b1;
      pstate_next    = P_HUNT;
      idle_cnt_next  = '0;
    end else if (byte_valid) begin
      case (pstate_reg)
        P_HUNT: begin
          if (byte_data == SYNC_BYTE) begin
            pstate_next = P_ADDR;
            idx_next    = '0;
            csum_next   = '0;
          end
        end
        P_ADDR: begin
          addr_sr_next = {addr_sr_reg[23:0], byte_data};
          csum_next    = csum_fold(csum_reg, byte_data);
          idx_next     = idx_reg + 3'd1;
          if (idx_reg == 3'd3) pstate_next = P_DATA;
        end
        P_DATA: begin
          data_sr_next = {data_sr_reg[23:0], byte_data};
          csum_next    = csum_fold(csum_reg, byte_data);
          idx_next     = idx_reg + 3'd1;
          if (idx_reg == 3'(FRAME_PAYLOAD_BYTES - 1)) pstate_next = P_CSUM;
        end
        P_CSUM: begin
          pstate_next = P_HUNT;
          if (byte_data == csum_reg) begin
            msg_en_next   = 1'b1;
            msg_addr_next = addr_sr_reg;
            msg_next      = data_sr_reg;
          end else begin
            frame_err_next = 1'b1;
          end
        end
        default: pstate_next = P_HUNT;
      endcase
    end
  end

  assign msg_en    = msg_en_reg;
  assign msg_addr  = msg_addr_reg;
  assign msg       = msg_reg;
  assign frame_err = frame_err_reg;
  assign busy      = (pstate_reg != P_HUNT);

endmodule
